// File: rtl/lb_uart_bridge.sv
`default_nettype none
// ============================================================================
// Module   : lb_uart_bridge
// Purpose  : Parses framed 'W'/'R' commands from a UART byte stream and issues
//            single-cycle local-bus write/read strobes. Read data (or
//            0xDEADBEEF on a read timeout) is returned MSB first on the tx side.
// Options  : define LB_UART_BRIDGE_WR_ACK_EN to answer every completed write
//            with a single 0x06 byte.
// Revision : 1.0 - initial release
// ============================================================================
module lb_uart_bridge #(
    parameter int RD_TIMEOUT  = 255,
    parameter int GAP_TIMEOUT = 65535
) (
    input  logic        clk_lb,
    input  logic        reset_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_rdy,
    output logic [7:0]  tx_byte,
    output logic        tx_rdy,
    input  logic        tx_busy,
    output logic        lb_wr,
    output logic        lb_rd,
    output logic [31:0] lb_addr,
    output logic [31:0] lb_wr_d,
    input  logic [31:0] lb_rd_d,
    input  logic        lb_rd_rdy,
    output logic        err_timeout
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_WR_CYC  = 3'd3;
    localparam logic [2:0] S_RD_CYC  = 3'd4;
    localparam logic [2:0] S_RD_WAIT = 3'd5;
    localparam logic [2:0] S_TX      = 3'd6;
`ifdef LB_UART_BRIDGE_WR_ACK_EN
    localparam logic [2:0] S_ACK     = 3'd7;
    localparam logic [7:0] C_ACK     = 8'h06;
`endif

    localparam logic [7:0]  C_CMD_WR  = 8'h57;
    localparam logic [7:0]  C_CMD_RD  = 8'h52;
    localparam logic [31:0] C_RD_ERR  = 32'hDEAD_BEEF;
    // Read timer is loaded one short so the error pulse lands exactly
    // RD_TIMEOUT cycles after the lb_rd cycle despite the output register.
    localparam logic [15:0] C_RD_LOAD  = 16'(RD_TIMEOUT - 1);
    localparam logic [15:0] C_GAP_LOAD = 16'(GAP_TIMEOUT);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic        r_is_write;
    logic [1:0]  r_byte_cnt;
    logic [15:0] r_gap_tmr;
    logic [15:0] r_rd_tmr;
    logic [31:0] r_tx_sh;
    logic [1:0]  r_tx_cnt;

    logic        w_start_frame;
    logic        w_shift_addr;
    logic        w_shift_data;
    logic        w_start_wr;
    logic        w_start_rd;
    logic        w_rd_done;
    logic        w_rd_err;
    logic        w_tx_go;
    logic        w_can_tx;
    logic [7:0]  w_tx_data;

    // State register
    always_ff @(posedge clk_lb) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state decode and per-cycle action strobes
    always_comb begin
        w_state_nxt   = r_state;
        w_start_frame = 1'b0;
        w_shift_addr  = 1'b0;
        w_shift_data  = 1'b0;
        w_start_wr    = 1'b0;
        w_start_rd    = 1'b0;
        w_rd_done     = 1'b0;
        w_rd_err      = 1'b0;
        w_tx_go       = 1'b0;
        w_tx_data     = r_tx_sh[31:24];
        // Blocking on tx_rdy gives the UART one cycle to raise tx_busy.
        w_can_tx      = !tx_busy && !tx_rdy;
        case (r_state)
            S_IDLE: begin
                if (rx_rdy && (rx_byte == C_CMD_WR || rx_byte == C_CMD_RD)) begin
                    w_start_frame = 1'b1;
                    w_state_nxt   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_rdy) begin
                    w_shift_addr = 1'b1;
                    if (r_byte_cnt == 2'd3) begin
                        if (r_is_write) begin
                            w_state_nxt = S_DATA;
                        end else begin
                            w_state_nxt = S_RD_CYC;
                            w_start_rd  = 1'b1;
                        end
                    end
                end else if (r_gap_tmr == 16'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_rdy) begin
                    w_shift_data = 1'b1;
                    if (r_byte_cnt == 2'd3) begin
                        w_state_nxt = S_WR_CYC;
                        w_start_wr  = 1'b1;
                    end
                end else if (r_gap_tmr == 16'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR_CYC: begin
`ifdef LB_UART_BRIDGE_WR_ACK_EN
                w_state_nxt = S_ACK;
`else
                w_state_nxt = S_IDLE;
`endif
            end
            S_RD_CYC: begin
                // A one-cycle timeout expires before any read data can be accepted.
                if (RD_TIMEOUT <= 1) begin
                    w_state_nxt = S_TX;
                    w_rd_err    = 1'b1;
                end else begin
                    w_state_nxt = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (lb_rd_rdy) begin
                    w_state_nxt = S_TX;
                    w_rd_done   = 1'b1;
                end else if (r_rd_tmr <= 16'd1) begin
                    w_state_nxt = S_TX;
                    w_rd_err    = 1'b1;
                end
            end
            S_TX: begin
                if (w_can_tx) begin
                    w_tx_go = 1'b1;
                    if (r_tx_cnt == 2'd3) w_state_nxt = S_IDLE;
                end
            end
`ifdef LB_UART_BRIDGE_WR_ACK_EN
            S_ACK: begin
                if (w_can_tx) begin
                    w_tx_go     = 1'b1;
                    w_tx_data   = C_ACK;
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs, shift registers and timers
    always_ff @(posedge clk_lb) begin
        if (!reset_n) begin
            lb_wr       <= 1'b0;
            lb_rd       <= 1'b0;
            tx_rdy      <= 1'b0;
            err_timeout <= 1'b0;
            lb_addr     <= '0;
            lb_wr_d     <= '0;
            tx_byte     <= '0;
            r_is_write  <= 1'b0;
            r_byte_cnt  <= '0;
            r_gap_tmr   <= '0;
            r_rd_tmr    <= '0;
            r_tx_sh     <= '0;
            r_tx_cnt    <= '0;
        end else begin
            lb_wr       <= w_start_wr;
            lb_rd       <= w_start_rd;
            err_timeout <= w_rd_err;
            tx_rdy      <= w_tx_go;

            if (w_start_frame) begin
                r_is_write <= (rx_byte == C_CMD_WR);
                r_byte_cnt <= '0;
            end else if (w_shift_addr || w_shift_data) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end

            if (w_shift_addr) lb_addr <= {lb_addr[23:0], rx_byte};
            if (w_shift_data) lb_wr_d <= {lb_wr_d[23:0], rx_byte};

            // Gap timer only matters in ADDR/DATA; it reloads on every byte.
            if (rx_rdy)                  r_gap_tmr <= C_GAP_LOAD;
            else if (r_gap_tmr != 16'd0) r_gap_tmr <= r_gap_tmr - 16'd1;

            if (r_state == S_RD_CYC)    r_rd_tmr <= C_RD_LOAD;
            else if (r_rd_tmr != 16'd0) r_rd_tmr <= r_rd_tmr - 16'd1;

            if (w_rd_done) begin
                r_tx_sh  <= lb_rd_d;
                r_tx_cnt <= '0;
            end else if (w_rd_err) begin
                r_tx_sh  <= C_RD_ERR;
                r_tx_cnt <= '0;
            end else if (w_tx_go) begin
                tx_byte  <= w_tx_data;
                r_tx_sh  <= {r_tx_sh[23:0], 8'h00};
                r_tx_cnt <= r_tx_cnt + 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lb_uart_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_lb_uart_bridge
// Purpose  : Self-checking bench for lb_uart_bridge: frame table plus gap and
//            reset corner sequences, with a scoreboard of bus and tx events.
// Options  : honours LB_UART_BRIDGE_WR_ACK_EN for write acknowledge bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lb_uart_bridge;

    localparam int RD_TO  = 8;
    localparam int GAP_TO = 16;

    logic        clk_lb    = 1'b0;
    logic        reset_n   = 1'b0;
    logic [7:0]  rx_byte   = '0;
    logic        rx_rdy    = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_rdy;
    logic        tx_busy   = 1'b0;
    logic        lb_wr;
    logic        lb_rd;
    logic [31:0] lb_addr;
    logic [31:0] lb_wr_d;
    logic [31:0] lb_rd_d   = '0;
    logic        lb_rd_rdy = 1'b0;
    logic        err_timeout;

    lb_uart_bridge #(
        .RD_TIMEOUT  (RD_TO),
        .GAP_TIMEOUT (GAP_TO)
    ) dut (
        .clk_lb      (clk_lb),
        .reset_n     (reset_n),
        .rx_byte     (rx_byte),
        .rx_rdy      (rx_rdy),
        .tx_byte     (tx_byte),
        .tx_rdy      (tx_rdy),
        .tx_busy     (tx_busy),
        .lb_wr       (lb_wr),
        .lb_rd       (lb_rd),
        .lb_addr     (lb_addr),
        .lb_wr_d     (lb_wr_d),
        .lb_rd_d     (lb_rd_d),
        .lb_rd_rdy   (lb_rd_rdy),
        .err_timeout (err_timeout)
    );

    always #5 clk_lb = ~clk_lb;

    typedef struct packed {
        logic [7:0]  kind;   // "W", "R" or "E" (read timeout)
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    typedef struct packed {
        logic [79:0] bytes;     // first byte in [79:72]
        logic [3:0]  nbytes;
        logic [7:0]  rd_delay;  // 0 = slave never answers
        logic [7:0]  kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    logic [7:0] exp_tx [$];
    ev_t        exp_bus [$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_rx = 0;
    int rd_cyc = 0;
    logic prev_tx = 1'b0;

    int          slave_delay = 0;
    logic [31:0] slave_data  = '0;
    int          busy_cnt    = 0;

    // UART transmitter model: busy for four cycles after each strobe
    always @(posedge clk_lb) begin
        if (tx_rdy) begin
            tx_busy  <= 1'b1;
            busy_cnt <= 4;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt <= 0;
            tx_busy  <= 1'b0;
        end
    end

    // Local-bus slave model: answers lb_rd after slave_delay cycles
    always @(negedge clk_lb) begin
        if (lb_rd && slave_delay > 0) begin
            repeat (slave_delay) @(posedge clk_lb);
            #1;
            lb_rd_d   = slave_data;
            lb_rd_rdy = 1'b1;
            @(posedge clk_lb);
            #1;
            lb_rd_rdy = 1'b0;
            lb_rd_d   = '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bus_event(input logic [7:0] kind);
        ev_t ev;
        if (exp_bus.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL bus_unexpected: got event %s, required none (cycle %0d)", kind, cyc);
        end else begin
            ev = exp_bus.pop_front();
            chk("bus_kind", 32'(kind), 32'(ev.kind));
            if (kind == "W") begin
                chk("wr_addr", lb_addr, ev.addr);
                chk("wr_data", lb_wr_d, ev.data);
                chk("wr_latency", 32'(cyc - last_rx), 32'd1);
            end else if (kind == "R") begin
                chk("rd_addr", lb_addr, ev.addr);
                chk("rd_latency", 32'(cyc - last_rx), 32'd1);
            end else begin
                chk("timeout_latency", 32'(cyc - rd_cyc), 32'(RD_TO));
            end
        end
    endtask

    // Scoreboard monitor, evaluated mid-cycle on the falling edge
    task automatic mon_step();
        logic [7:0] eb;
        cyc++;
        if (rx_rdy) last_rx = cyc;
        if (tx_rdy) begin
            chk("tx_while_busy", 32'(tx_busy), 32'd0);
            chk("tx_back_to_back", 32'(prev_tx), 32'd0);
            if (exp_tx.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_unexpected: got byte %0h, required no byte (cycle %0d)", tx_byte, cyc);
            end else begin
                eb = exp_tx.pop_front();
                chk("tx_byte", 32'(tx_byte), 32'(eb));
            end
        end
        prev_tx = tx_rdy;
        if (lb_wr) bus_event("W");
        if (lb_rd) begin
            bus_event("R");
            rd_cyc = cyc;
        end
        if (err_timeout) bus_event("E");
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_lb);
        #1;
        rx_byte = b;
        rx_rdy  = 1'b1;
        @(posedge clk_lb);
        #1;
        rx_rdy  = 1'b0;
        repeat (2) @(posedge clk_lb);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) exp_tx.push_back(w[8*k +: 8]);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0) && k < 400) begin
            @(negedge clk_lb);
            k++;
        end
        n_cmp++;
        if (exp_tx.size() != 0 || exp_bus.size() != 0) begin
            n_bad++;
            $display("FAIL drain_%s: %0d tx bytes and %0d bus events outstanding, required 0",
                     name, exp_tx.size(), exp_bus.size());
            exp_tx.delete();
            exp_bus.delete();
        end
        repeat (4) @(negedge clk_lb);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_lb_wr"},       32'(lb_wr),       32'd0);
        chk({tag, "_lb_rd"},       32'(lb_rd),       32'd0);
        chk({tag, "_tx_rdy"},      32'(tx_rdy),      32'd0);
        chk({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
        chk({tag, "_lb_addr"},     lb_addr,          32'd0);
        chk({tag, "_lb_wr_d"},     lb_wr_d,          32'd0);
        chk({tag, "_tx_byte"},     32'(tx_byte),     32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            forever begin
                @(negedge clk_lb);
                mon_step();
            end
        join_none

        vecs[0] = '{bytes: {8'h57, 32'h0000_0000, 32'h1122_3344, 8'h00}, nbytes: 4'd9,
                    rd_delay: 8'd0, kind: "W", addr: 32'h0, wdata: 32'h1122_3344,
                    rdata: 32'h0, exp_err: 1'b0};
        vecs[1] = '{bytes: {8'h52, 32'h0000_0004, 40'h0}, nbytes: 4'd5,
                    rd_delay: 8'd3, kind: "R", addr: 32'h4, wdata: 32'h0,
                    rdata: 32'hCAFE_F00D, exp_err: 1'b0};
        vecs[2] = '{bytes: {8'h52, 32'h0000_0010, 40'h0}, nbytes: 4'd5,
                    rd_delay: 8'd0, kind: "R", addr: 32'h10, wdata: 32'h0,
                    rdata: 32'h0, exp_err: 1'b1};
        vecs[3] = '{bytes: {8'h41, 8'h57, 32'h1234_5678, 32'hA5A5_A5A5}, nbytes: 4'd10,
                    rd_delay: 8'd0, kind: "W", addr: 32'h1234_5678, wdata: 32'hA5A5_A5A5,
                    rdata: 32'h0, exp_err: 1'b0};
        vecs[4] = '{bytes: {8'h57, 32'hFFFF_FFFF, 32'h0000_0000, 8'h00}, nbytes: 4'd9,
                    rd_delay: 8'd0, kind: "W", addr: 32'hFFFF_FFFF, wdata: 32'h0,
                    rdata: 32'h0, exp_err: 1'b0};
        vecs[5] = '{bytes: {8'h52, 32'h0000_0100, 40'h0}, nbytes: 4'd5,
                    rd_delay: 8'd7, kind: "R", addr: 32'h100, wdata: 32'h0,
                    rdata: 32'h0BAD_F00D, exp_err: 1'b0};
        vecs[6] = '{bytes: {8'h52, 32'h0000_0200, 40'h0}, nbytes: 4'd5,
                    rd_delay: 8'd8, kind: "R", addr: 32'h200, wdata: 32'h0,
                    rdata: 32'h55AA_55AA, exp_err: 1'b1};
        vecs[7] = '{bytes: {8'h00, 8'hFF, 8'h52, 32'h0000_0040, 24'h0}, nbytes: 4'd7,
                    rd_delay: 8'd1, kind: "R", addr: 32'h40, wdata: 32'h0,
                    rdata: 32'h89AB_CDEF, exp_err: 1'b0};

        // Power-on reset state
        repeat (3) @(posedge clk_lb);
        @(negedge clk_lb);
        check_reset_values("por");
        @(posedge clk_lb);
        #1;
        reset_n = 1'b1;

        // Frame table
        for (int i = 0; i < NV; i++) begin
            slave_delay = int'(vecs[i].rd_delay);
            slave_data  = vecs[i].rdata;
            if (vecs[i].kind == "W") begin
                exp_bus.push_back('{kind: "W", addr: vecs[i].addr, data: vecs[i].wdata});
`ifdef LB_UART_BRIDGE_WR_ACK_EN
                exp_tx.push_back(8'h06);
`endif
            end else begin
                exp_bus.push_back('{kind: "R", addr: vecs[i].addr, data: 32'h0});
                if (vecs[i].exp_err) begin
                    exp_bus.push_back('{kind: "E", addr: 32'h0, data: 32'h0});
                    push_word(32'hDEAD_BEEF);
                end else begin
                    push_word(vecs[i].rdata);
                end
            end
            for (int b = 0; b < int'(vecs[i].nbytes); b++)
                send_byte(vecs[i].bytes[79 - 8*b -: 8]);
            drain($sformatf("vec%0d", i));
        end

        // Gap timeout: abandoned write prefix, then a full read
        slave_delay = 2;
        slave_data  = 32'h1357_9BDF;
        exp_bus.push_back('{kind: "R", addr: 32'h8, data: 32'h0});
        push_word(32'h1357_9BDF);
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (20) @(posedge clk_lb);
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h08);
        drain("gap");

        // Reset during RD_WAIT; slave data arrives after release
        slave_delay = 6;
        slave_data  = 32'h600D_F00D;
        exp_bus.push_back('{kind: "R", addr: 32'h20, data: 32'h0});
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h20);
        #1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk_lb);
        @(negedge clk_lb);
        check_reset_values("rst_mid");
        @(posedge clk_lb);
        #1;
        reset_n = 1'b1;
        repeat (30) @(negedge clk_lb);
        check_reset_values("post_rst");
        drain("reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
